// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
//   state_e    : sequencer FSM states
//   LOSS_CNT_W : width of the saturating lock-loss counter
//   cnt_width  : bits needed to hold values 0..max_val
//   max_u      : larger of two unsigned values
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLLRST,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } state_e;

  localparam int unsigned LOSS_CNT_W = 8;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous bit.
//   i_clk : destination clock
//   i_rst : asynchronous active-high reset, clears every stage to 0
//   i_d   : asynchronous input bit
//   o_q   : synchronised output, STAGES cycles of latency
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset pin, qualifies the asynchronous LOCK signal (synchronise, debounce,
// timeout with retry) and then releases NUM_DOMAINS downstream resets in index order.
//   i_clk             : free-running reference clock
//   i_rst             : asynchronous active-high reset
//   i_locked_in       : PLL LOCK, asynchronous to i_clk
//   i_force_relock    : one-cycle request to re-run the whole sequence
//   o_pll_rst         : PLL RST drive, active-high
//   o_rst_out         : per-domain active-high resets, bit 0 released first
//   o_all_ready       : high only when every o_rst_out bit is low
//   o_lock_loss_count : saturating count of lock losses seen during release or run
//   o_timeout_err     : sticky flag, set on any lock timeout
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS   = 4,
  parameter int unsigned STAGE_DELAY   = 16,
  parameter int unsigned LOCK_STABLE   = 1024,
  parameter int unsigned LOCK_TIMEOUT  = 1048576,
  parameter int unsigned PLLRST_CYCLES = 32,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_locked_in,
  input  logic                   i_force_relock,
  output logic                   o_pll_rst,
  output logic [NUM_DOMAINS-1:0] o_rst_out,
  output logic                   o_all_ready,
  output logic [LOSS_CNT_W-1:0]  o_lock_loss_count,
  output logic                   o_timeout_err
);

  // One shared counter serves every state; it is cleared on each state entry.
  localparam int unsigned CNT_MAX =
    max_u(max_u(PLLRST_CYCLES, LOCK_TIMEOUT), max_u(LOCK_STABLE, STAGE_DELAY));
  localparam int unsigned CNT_W = cnt_width(CNT_MAX);
  localparam int unsigned STG_W = cnt_width(NUM_DOMAINS);

  localparam logic [CNT_W-1:0] PLLRST_LAST  = CNT_W'(PLLRST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST   = CNT_W'(STAGE_DELAY - 1);
  localparam logic [STG_W-1:0] DOMAIN_LAST  = STG_W'(NUM_DOMAINS - 1);

  state_e                   r_state, w_state_d;
  logic [CNT_W-1:0]         r_cnt, w_cnt_d;
  logic [STG_W-1:0]         r_stage, w_stage_d;
  logic                     r_pll_rst, w_pll_rst_d;
  logic [NUM_DOMAINS-1:0]   r_rst_out, w_rst_out_d;
  logic                     r_all_ready, w_all_ready_d;
  logic [LOSS_CNT_W-1:0]    r_loss_cnt, w_loss_cnt_d;
  logic                     r_timeout_err, w_timeout_err_d;
  logic                     w_lock_s;
  logic                     w_restart;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_d  (i_locked_in),
    .o_q  (w_lock_s)
  );

  always_comb begin
    w_state_d       = r_state;
    w_cnt_d         = r_cnt + 1'b1;
    w_stage_d       = r_stage;
    w_pll_rst_d     = 1'b0;
    w_rst_out_d     = r_rst_out;
    w_loss_cnt_d    = r_loss_cnt;
    w_timeout_err_d = r_timeout_err;
    w_restart       = 1'b0;

    unique case (r_state)
      PLLRST: begin
        w_pll_rst_d = 1'b1;
        if (r_cnt == PLLRST_LAST) begin
          w_state_d   = WAIT_LOCK;
          w_cnt_d     = '0;
          w_pll_rst_d = 1'b0;
        end
      end
      WAIT_LOCK: begin
        if (i_force_relock) begin
          w_restart = 1'b1;
        end else if (w_lock_s) begin
          // Lock beats a coincident timeout.
          w_state_d = STABLE;
          w_cnt_d   = '0;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_timeout_err_d = 1'b1;
          w_restart       = 1'b1;
        end
      end
      STABLE: begin
        if (i_force_relock) begin
          w_restart = 1'b1;
        end else if (!w_lock_s) begin
          // A glitch before release only restarts debouncing; not a loss.
          w_state_d = WAIT_LOCK;
          w_cnt_d   = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_d = RELEASE;
          w_cnt_d   = '0;
          w_stage_d = '0;
        end
      end
      RELEASE, RUN: begin
        if (!w_lock_s) begin
          w_loss_cnt_d = (r_loss_cnt == {LOSS_CNT_W{1'b1}}) ? r_loss_cnt
                                                             : r_loss_cnt + 1'b1;
          w_restart    = 1'b1;
        end else if (i_force_relock) begin
          w_restart = 1'b1;
        end else if (r_state == RUN) begin
          w_cnt_d = r_cnt;
        end else if (r_cnt == STAGE_LAST) begin
          w_cnt_d              = '0;
          w_rst_out_d[r_stage] = 1'b0;
          w_stage_d            = r_stage + 1'b1;
          if (r_stage == DOMAIN_LAST) begin
            w_state_d = RUN;
          end
        end
      end
      default: begin
        w_restart = 1'b1;
      end
    endcase

    // Every restart re-asserts all domains at once and re-pulses the PLL.
    if (w_restart) begin
      w_state_d   = PLLRST;
      w_cnt_d     = '0;
      w_stage_d   = '0;
      w_pll_rst_d = 1'b1;
      w_rst_out_d = {NUM_DOMAINS{1'b1}};
    end

    w_all_ready_d = (w_state_d == RUN);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= PLLRST;
      r_cnt         <= '0;
      r_stage       <= '0;
      r_pll_rst     <= 1'b1;
      r_rst_out     <= {NUM_DOMAINS{1'b1}};
      r_all_ready   <= 1'b0;
      r_loss_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_cnt         <= w_cnt_d;
      r_stage       <= w_stage_d;
      r_pll_rst     <= w_pll_rst_d;
      r_rst_out     <= w_rst_out_d;
      r_all_ready   <= w_all_ready_d;
      r_loss_cnt    <= w_loss_cnt_d;
      r_timeout_err <= w_timeout_err_d;
    end
  end

  assign o_pll_rst         = r_pll_rst;
  assign o_rst_out         = r_rst_out;
  assign o_all_ready       = r_all_ready;
  assign o_lock_loss_count = r_loss_cnt;
  assign o_timeout_err     = r_timeout_err;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Parametrised successor to the fixed-frequency ECP5 PLL wrapper. It actively drives the PLL RST pin and qualifies the asynchronous LOCK signal: it synchronises LOCK, debounces it, and times out with a retry if lock never comes. It then releases NUM_DOMAINS downstream reset outputs in a staged order, and re-sequences on lock loss or on request. It sits between the EHXPLLL instance and every SoC block reset, and runs on the free-running board reference clock.

Parameters:
NUM_DOMAINS, 4, number of staged reset outputs (1..16)
STAGE_DELAY, 16, cycles between successive reset releases (>=1)
LOCK_STABLE, 1024, consecutive synchronised-lock cycles required before release (>=1)
LOCK_TIMEOUT, 1048576, cycles allowed in WAIT_LOCK before a PLL reset retry (>=1)
PLLRST_CYCLES, 32, width of each pll_rst pulse in cycles (>=1)
SYNC_STAGES, 2, flops in the locked_in synchroniser (>=2)

Ports:
clk  in  1  reference clock (25 MHz board clock)
rst  in  1  asynchronous active-high reset
locked_in  in  1  PLL LOCK output, asynchronous to clk
force_relock  in  1  synchronous one-cycle request to re-run the full sequence
pll_rst  out  1  drive to PLL RST, active-high
rst_out  out  NUM_DOMAINS  per-domain active-high resets; bit 0 released first
all_ready  out  1  high only when every rst_out bit is low
lock_loss_count  out  8  saturating count of lock losses after release began
timeout_err  out  1  sticky: at least one LOCK_TIMEOUT expiry since rst

Behaviour:
- Reset (async, rst=1): state=PLLRST, pll_rst=1, rst_out=all ones, all_ready=0, lock_loss_count=0, timeout_err=0, all counters=0, synchroniser flops=0.
- lock_s: locked_in through SYNC_STAGES flops; latency SYNC_STAGES cycles.
- All outputs registered.
- PLLRST: pll_rst=1 for exactly PLLRST_CYCLES cycles, then WAIT_LOCK. rst_out all ones.
- WAIT_LOCK: pll_rst=0; timeout counter runs from 0.
  - lock_s=1 -> STABLE.
  - Counter reaches LOCK_TIMEOUT with lock_s=0 -> timeout_err<=1 (sticky), go to PLLRST.
- STABLE: counter increments while lock_s=1.
  - lock_s=0 -> WAIT_LOCK with counters cleared; not counted as a loss.
  - Counter reaches LOCK_STABLE -> RELEASE.
- RELEASE: stage counter starts from 0 on entry. rst_out[i] deasserts on the edge STAGE_DELAY*(i+1) cycles after entry. The edge that clears rst_out[NUM_DOMAINS-1] also moves the FSM to RUN.
- RUN: all_ready=1, registered (state==RUN).
- Lock loss in RELEASE or RUN (lock_s=0), same edge:
  - rst_out<=all ones, all_ready<=0.
  - lock_loss_count<=min(count+1,255).
  - Go to PLLRST.
  - Net latency: SYNC_STAGES+1 cycles from a locked_in fall.
- force_relock=1 in any state other than PLLRST: same as lock loss but lock_loss_count is unchanged. Ignored while in PLLRST.
- Simultaneous events:
  - Lock loss and force_relock together: counts as a lock loss.
  - Timeout and lock_s rising on the same cycle: lock wins, go to STABLE.
- Reset released only in index order. Resets are asserted all at once, never partially.
- Counter widths: $clog2(max(param)+1). No wrap: each counter clears on every state entry.
- rst asserted mid-operation: immediate return to the reset values above, including clearing sticky and count outputs.

Decomposition:
- Package pll_seq_pkg:
  - state enum {PLLRST, WAIT_LOCK, STABLE, RELEASE, RUN}
  - LOSS_CNT_W=8
  - helper function for counter widths
- Sub-module sync_ff (parameter STAGES, async active-high reset to 0). Reused for other CDC single bits in the SoC.
- The FSM and counters live in pll_reset_sequencer.

Test Plan:
Bench parameters: NUM_DOMAINS=3, STAGE_DELAY=4, LOCK_STABLE=8, LOCK_TIMEOUT=64, PLLRST_CYCLES=5, SYNC_STAGES=2.
1. Release rst; hold locked_in=1 from cycle 0 -> pll_rst high 5 cycles; rst_out bits fall at 4, 8 and 12 cycles after STABLE completes; all_ready=1 from the cycle rst_out==3'b000; lock_loss_count=0.
2. After 5 stable cycles, drop locked_in 1 cycle -> returns to WAIT_LOCK, stability restarts, rst_out stays 3'b111, lock_loss_count=0, no pll_rst pulse.
3. locked_in held 0 -> after 64 WAIT_LOCK cycles timeout_err=1 and a new 5-cycle pll_rst pulse; repeats every 69 cycles; timeout_err stays 1 after a later lock.
4. In RUN, drop locked_in -> rst_out=3'b111 and all_ready=0 exactly 3 cycles later; lock_loss_count=1; pll_rst pulse follows. Same check with force_relock -> count unchanged.
5. 260 lock-loss events -> lock_loss_count saturates at 255 and does not wrap.
6. Assert rst mid-RELEASE (rst_out=3'b110) -> same cycle rst_out=3'b111, pll_rst=1, timeout_err=0, lock_loss_count=0; full sequence repeats after release.
